mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline, owning HI/LO.
//  Drives the busy signal consumed by the hazard/stall unit (stall = busy & D-stage-is-MD-instr).
//  Serves MFHI/MFLO reads combinationally and MTHI/MTLO writes in one cycle.
//  Honours the exception/interrupt request so a flushed instruction never mutates HI/LO.
// PARAMETERS
//  MULT_CYCLES  5   registered busy cycles after start for MULT/MULTU
//  DIV_CYCLES   10  registered busy cycles after start for DIV/DIVU
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  reset    in   1   synchronous, active-high; clears all state
//  start    in   1   E-stage instr is MULT/MULTU/DIV/DIVU (one-cycle pulse)
//  mdu_op   in   4   operation code (package encoding), valid with the E-stage instr
//  req      in   1   exception/interrupt flush this cycle; suppresses start and MTHI/MTLO
//  A        in   32  rs operand (forwarded value)
//  B        in   32  rt operand (forwarded value)
//  busy     out  1   unit occupied; includes the accepted start cycle
//  rdata    out  32  MFHI -> HI, MFLO -> LO, otherwise 32'h0 (combinational)
//  hi       out  32  current HI register
//  lo       out  32  current LO register
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, HI=LO=0, temp result 0; busy=0, rdata=0.
//  - accept = start & ~req & (state==IDLE); busy = accept | (state==BUSY).
//  - FSM IDLE->BUSY on accept: latch {temp_hi,temp_lo} from A/B, cnt = MULT_CYCLES or DIV_CYCLES.
//  - BUSY: cnt decrements each cycle; when cnt==1, commit temp to HI/LO and go to IDLE.
//  - Timing: start at cycle t -> busy high t..t+N (N = cycle param); new HI/LO visible from t+N+1.
//  - MULT: signed 64-bit product, {HI,LO}. MULTU: unsigned product.
//  - DIV: signed, quotient truncates toward zero -> LO; remainder, sign of dividend -> HI.
//  - DIVU: unsigned; LO = quotient, HI = remainder.
//  - DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
//  - Divide by zero (either form): full busy period, HI/LO unchanged at commit.
//  - MTHI/MTLO: write A into HI/LO at the edge when ~req & state==IDLE; ignored when busy.
//  - start while BUSY: ignored, no restart (stall unit prevents this; defined for safety).
//  - start with req=1: not accepted, busy stays 0, HI/LO untouched.
//  - req during BUSY: does NOT abort; the op was already committed past the flush point.
//  - reset mid-operation: abort, no commit; HI=LO=0 next cycle.
//  - rdata during BUSY returns pre-operation HI/LO (stall unit guarantees no such read).
// STRUCTURE
//  - Shared package (mdu_pkg): MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6,
//    MTHI=7, MTLO=8; FSM state typedef {IDLE, BUSY}; default cycle constants.
//  - Counter width = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
//  - One natural sub-module: mdu_arith (combinational 64-bit result from op/A/B,
//    div-by-zero flag); mdu_unit holds the FSM, counter, temp, HI/LO, busy and rdata muxing.
// TESTING
//  - MULT A=32'hFFFFFFFF, B=2 at t -> busy t..t+5; at t+6 HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
//  - MULTU same operands -> HI=32'h00000001, LO=32'hFFFFFFFE after 6 busy cycles.
//  - DIV A=-7, B=2 -> busy t..t+10; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; MFLO then rdata=LO.
//  - DIVU B=0 with HI=32'h11, LO=32'h22 -> busy 11 cycles, HI/LO stay 32'h11/32'h22.
//  - reset at 3rd busy cycle of MULT -> next cycle busy=0, HI=LO=0, no later commit.
//  - start=1 req=1 -> busy=0; MTHI A=5 with req=1 -> HI unchanged; MTLO A=9 while busy -> ignored.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: operation codes, FSM states
// and default latency constants.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_BUSY = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide result {HI,LO} for one MDU operation,
// with a divide-by-zero flag so the caller can suppress the commit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        dbz_o
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] b_safe;
    logic        [31:0] b_mag_safe;
    logic        [31:0] sq_mag;
    logic        [31:0] sr_mag;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               b_zero;
    logic               q_neg;

    assign b_zero = (b_i == 32'd0);

    assign a_sx   = {{32{a_i[31]}}, a_i};
    assign b_sx   = {{32{b_i[31]}}, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide works on magnitudes; |0x80000000| still fits as an unsigned value,
    // which makes the 0x80000000 / -1 case fall out naturally as 0x80000000 rem 0.
    assign a_mag = a_i[31] ? (~a_i + 32'd1) : a_i;
    assign b_mag = b_i[31] ? (~b_i + 32'd1) : b_i;

    // A zero divisor is replaced by 1 to keep the dividers defined; the result is discarded.
    assign b_safe     = b_zero ? 32'd1 : b_i;
    assign b_mag_safe = b_zero ? 32'd1 : b_mag;

    assign sq_mag = a_mag / b_mag_safe;
    assign sr_mag = a_mag % b_mag_safe;
    assign uq     = a_i / b_safe;
    assign ur     = a_i % b_safe;
    assign q_neg  = a_i[31] ^ b_i[31];

    always_comb begin
        res_o = 64'd0;
        dbz_o = 1'b0;
        case (op_i)
            MDU_MULT:  res_o = prod_s;
            MDU_MULTU: res_o = prod_u;
            MDU_DIV: begin
                dbz_o = b_zero;
                res_o = {(a_i[31] ? (~sr_mag + 32'd1) : sr_mag),
                         (q_neg   ? (~sq_mag + 32'd1) : sq_mag)};
            end
            MDU_DIVU: begin
                dbz_o = b_zero;
                res_o = {ur, uq};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO: busy-window FSM, deferred
// HI/LO commit, single-cycle MTHI/MTLO and combinational MFHI/MFLO read port.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        temp_q, temp_d;
    logic               dbz_q, dbz_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        arith_res;
    logic               arith_dbz;
    logic               idle;
    logic               accept;

    mdu_arith u_arith (
        .op_i  (mdu_op),
        .a_i   (A),
        .b_i   (B),
        .res_o (arith_res),
        .dbz_o (arith_dbz)
    );

    assign idle   = (state_q == S_IDLE);
    assign accept = start & ~req & idle;
    assign busy   = accept | (state_q == S_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    temp_d  = arith_res;
                    dbz_d   = arith_dbz;
                    cnt_d   = op_is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
                // Moves to HI/LO only land when the instruction survives the flush.
                if (!req && mdu_op == MDU_MTHI) begin
                    hi_d = A;
                end
                if (!req && mdu_op == MDU_MTLO) begin
                    lo_d = A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!dbz_q) begin
                        hi_d = temp_q[63:32];
                        lo_d = temp_q[31:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            temp_q  <= 64'd0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (mdu_op == MDU_MFHI) begin
            rdata = hi_q;
        end else if (mdu_op == MDU_MFLO) begin
            rdata = lo_q;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit against a plain-arithmetic HI/LO model.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        req;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .req    (req),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .rdata  (rdata),
        .hi     (hi_o),
        .lo     (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // HI/LO after an operation completes, from the architectural definition.
    task automatic ref_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned pu;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (op)
            MDU_MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MDU_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            MDU_DIV: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MDU_DIVU: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic quiet();
        start  = 1'b0;
        req    = 1'b0;
        mdu_op = MDU_NONE;
        A      = $urandom;
        B      = $urandom;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 7)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one MULT/DIV op; with noise, random start/req/MT* traffic hits the busy window.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise);
        int n;
        int nb;
        n  = (op == MDU_DIV || op == MDU_DIVU) ? NDIV : NMUL;
        nb = 0;
        @(posedge clk); #1;
        quiet();
        start = 1'b1; mdu_op = op; A = a; B = b;
        #1 if (busy === 1'b1) nb++;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            quiet();
            if (noise) begin
                start  = 1'($urandom);
                req    = 1'($urandom);
                mdu_op = 4'($urandom_range(1, 8));
            end
            #1 if (busy === 1'b1) nb++;
            if (k == n) check_eq("hold_hi", hi_o, m_hi);
        end
        ref_apply(op, a, b);
        @(posedge clk); #1;
        quiet();
        #1;
        check_eq("busy_len", nb, n + 1);
        check_eq("busy_done", busy, 1'b0);
        check_eq("hi", hi_o, m_hi);
        check_eq("lo", lo_o, m_lo);
        mdu_op = MDU_MFHI;
        #1 check_eq("mfhi", rdata, m_hi);
        mdu_op = MDU_MFLO;
        #1 check_eq("mflo", rdata, m_lo);
        mdu_op = MDU_NONE;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic rq);
        @(posedge clk); #1;
        quiet();
        mdu_op = op; A = a; req = rq;
        @(posedge clk); #1;
        quiet();
        if (!rq) begin
            if (op == MDU_MTHI) m_hi = a;
            else m_lo = a;
        end
        #1;
        check_eq("mt_hi", hi_o, m_hi);
        check_eq("mt_lo", lo_o, m_lo);
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_hi", hi_o, 32'd0);
        check_eq("rst_lo", lo_o, 32'd0);
        mdu_op = MDU_MFHI;
        #1 check_eq("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        mdu_op = MDU_NONE;

        do_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check_eq("mult_hi_k", hi_o, 32'hFFFF_FFFF);
        check_eq("mult_lo_k", lo_o, 32'hFFFF_FFFE);
        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check_eq("multu_hi_k", hi_o, 32'h0000_0001);
        check_eq("multu_lo_k", lo_o, 32'hFFFF_FFFE);
        do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_hi_k", hi_o, 32'hFFFF_FFFF);
        check_eq("div_lo_k", lo_o, 32'hFFFF_FFFD);
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_eq("divovf_hi_k", hi_o, 32'd0);
        check_eq("divovf_lo_k", lo_o, 32'h8000_0000);

        mt(MDU_MTHI, 32'h11, 1'b0);
        mt(MDU_MTLO, 32'h22, 1'b0);
        do_op(MDU_DIVU, $urandom, 32'd0, 1'b1);
        check_eq("dbz_hi_k", hi_o, 32'h11);
        check_eq("dbz_lo_k", lo_o, 32'h22);

        // reset during the third busy cycle of a MULT
        @(posedge clk); #1;
        quiet(); start = 1'b1; mdu_op = MDU_MULT; A = 32'd7; B = 32'd9;
        @(posedge clk); #1;
        quiet();
        @(posedge clk); #1;
        quiet(); reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        #1;
        check_eq("rstmid_busy", busy, 1'b0);
        check_eq("rstmid_hi", hi_o, 32'd0);
        check_eq("rstmid_lo", lo_o, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("rstmid_late_lo", lo_o, 32'd0);

        mt(MDU_MTHI, 32'h33, 1'b0);
        // start with req: not accepted
        @(posedge clk); #1;
        quiet(); start = 1'b1; req = 1'b1; mdu_op = MDU_MULT; A = 32'd3; B = 32'd4;
        #1 check_eq("req_busy", busy, 1'b0);
        @(posedge clk); #1;
        quiet();
        #1;
        check_eq("req_busy_next", busy, 1'b0);
        check_eq("req_hi", hi_o, m_hi);
        check_eq("req_lo", lo_o, m_lo);
        mt(MDU_MTHI, 32'd5, 1'b1);

        // MTLO while busy is ignored
        @(posedge clk); #1;
        quiet(); start = 1'b1; mdu_op = MDU_MULT; A = 32'd3; B = 32'd5;
        @(posedge clk); #1;
        quiet(); mdu_op = MDU_MTLO; A = 32'd9;
        @(posedge clk); #1;
        quiet();
        #1 check_eq("mtlo_busy", lo_o, m_lo);
        repeat (4) @(posedge clk);
        #1;
        ref_apply(MDU_MULT, 32'd3, 32'd5);
        check_eq("mtlo_busy_done", busy, 1'b0);
        check_eq("mtlo_busy_lo", lo_o, 32'd15);

        for (int i = 0; i < 60; i++) begin
            if (($urandom % 10) < 8) begin
                do_op(4'($urandom_range(1, 4)), pick_operand(), pick_operand(), 1'($urandom));
            end else begin
                mt(($urandom % 2) ? MDU_MTHI : MDU_MTLO, $urandom, 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
